branch_resolve_ctrl: RTL and testbench
======================================

Name: branch_resolve_ctrl

Overview:
- Dynamic branch prediction and misprediction-recovery controller for the 5-stage RV32I pipeline.
- Supplies a direction prediction to decode from a 2-bit saturating-counter table (BHT).
- Checks each resolved branch in execute against its prediction. On a miss it redirects the PC and sequences the IF/ID and ID/EX flushes.
- Replaces the static opcode-only taken decision in decode.

Parameters:
- XLEN, 32, address/PC width.
- BHT_ENTRIES, 16, number of 2-bit counters; must be a power of two. IDX_W = log2(BHT_ENTRIES).
- FLUSH_CYCLES, 2, number of cycles the flush outputs stay asserted after a misprediction; range 1..7.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active-low.
- id_valid  in  1  decode slot holds a valid instruction.
- id_op  in  7  opcode of the instruction in decode.
- id_pc  in  XLEN  PC of the instruction in decode.
- pred_taken  out  1  prediction for the decode instruction (combinational).
- ex_valid  in  1  execute slot holds a valid instruction.
- ex_is_branch  in  1  execute instruction is B-type (opcode 1100011).
- ex_pc  in  XLEN  PC of the execute instruction.
- ex_taken  in  1  actual branch outcome.
- ex_pred_taken  in  1  prediction carried down the pipe with this instruction.
- ex_target  in  XLEN  computed branch target.
- redirect_valid  out  1  one-cycle PC redirect strobe.
- redirect_pc  out  XLEN  corrected fetch PC.
- flush_if_id  out  1  clear the IF/ID register.
- flush_id_ex  out  1  clear the ID/EX register.
- branch_cnt  out  16  count of resolved B-type branches, saturating.
- mispred_cnt  out  16  count of mispredictions, saturating.

Behaviour:
- Reset (async, rst=0):
  - state=IDLE, flush counter=0.
  - All registered outputs = 0: redirect_valid, redirect_pc, both flushes, both counters.
  - Every BHT entry = 2'b01 (weakly not-taken).
  - Reset asserted during FLUSH aborts the flush immediately.
- Prediction (combinational, no latency), index = id_pc[IDX_W+1:2]:
  - id_op=1101111 (JAL): pred_taken=1.
  - id_op=1100011: pred_taken = BHT[index][1].
  - Otherwise, or id_valid=0: pred_taken=0.
- Resolution: considered only when ex_valid & ex_is_branch & state==IDLE.
  - BHT update, registered write at the next edge: taken increments the counter, saturating at 11; not-taken decrements it, saturating at 00.
  - branch_cnt increments by 1 per resolution, saturating at 16'hFFFF.
- Mispredict = resolution & (ex_taken != ex_pred_taken). Detected in cycle t:
  - t+1: redirect_valid=1 for exactly one cycle.
  - redirect_pc = ex_taken ? ex_target : ex_pc+4. The +4 is modulo 2^XLEN, so it wraps at the top of the address space.
  - flush_if_id and flush_id_ex = 1 from t+1 through t+FLUSH_CYCLES inclusive.
  - mispred_cnt increments by 1, saturating.
  - state goes to FLUSH.
- State machine:
  - IDLE -> FLUSH on mispredict; load the flush counter with FLUSH_CYCLES.
  - FLUSH: decrement the counter each cycle; go to IDLE when it reaches 1.
  - FLUSH ignores all ex_* inputs (wrong-path): no BHT update, no count, no new redirect.
- Correct predictions: no redirect, no flush; the BHT and branch_cnt still update.
- Same-cycle BHT read and write to the same index: the read returns the old value (no bypass).
- Aliasing: PCs with equal index bits share a counter. This is intended; no tag is kept.
- redirect_pc holds its last value when redirect_valid=0.

Decomposition:
- Shared package (rv_pkg):
  - opcode constants OP_BRANCH=7'b1100011, OP_JAL=7'b1101111.
  - controller state enum {IDLE, FLUSH}.
  - counter encodings SNT=00, WNT=01, WT=10, ST=11.
- One sub-module, bht_2bit:
  - counter array with async reset to WNT.
  - one combinational read port and one registered saturating-update port.
- Top level holds the FSM, flush counter, redirect logic and statistics counters.

Test Plan:
- Reset then release, id_op=1100011, id_pc=0x40 -> pred_taken=0; all outputs 0; cnts=0.
- id_op=1101111 at any PC -> pred_taken=1; id_op=0110011 -> pred_taken=0.
- Taken misprediction, ex_pc=0x200, ex_taken=1, ex_pred_taken=0, ex_target=0x180:
  - next cycle redirect_valid=1, redirect_pc=0x180.
  - flushes high for exactly 2 cycles.
  - mispred_cnt=1, branch_cnt=1.
  - BHT[0] goes 01->10, so pred for 0x200 becomes 1.
  - an ex_valid branch during FLUSH changes nothing.
- Not-taken misprediction, ex_pc=0x300, pred=1, taken=0 -> redirect_pc=0x304.
- Correct prediction, ex_pc=0x200 taken, pred=1 -> no redirect or flush; counter 10->11; branch_cnt increments.
- Aliasing with 16 entries, PCs 0x100 and 0x140:
  - train 0x100 taken three times -> pred for 0x140 = 1.
  - a same-cycle read of index 0 during a write returns the old value.
- Counter saturation:
  - four not-taken resolutions drive the counter to 00 and it stays there.
  - force branch_cnt to 16'hFFFF, resolve one more branch -> branch_cnt stays 16'hFFFF.
- Assert rst mid-FLUSH -> flushes drop immediately, state=IDLE, BHT returns to 01.

Source files
------------

// File: rtl/rv_pkg.sv
// Shared definitions for the RV32I pipeline control blocks: opcodes,
// branch-controller state encoding and 2-bit predictor counter helpers.
package rv_pkg;

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef enum logic {
    IDLE,
    FLUSH
  } ctrl_state_e;

  localparam logic [1:0] CTR_SNT = 2'b00;
  localparam logic [1:0] CTR_WNT = 2'b01;
  localparam logic [1:0] CTR_WT  = 2'b10;
  localparam logic [1:0] CTR_ST  = 2'b11;

  // Saturating 2-bit counter step: taken moves toward ST, not-taken toward SNT.
  function automatic logic [1:0] ctr_update(input logic [1:0] ctr, input logic taken);
    logic [1:0] nxt;
    nxt = ctr;
    if (taken && ctr != CTR_ST) nxt = ctr + 2'd1;
    else if (!taken && ctr != CTR_SNT) nxt = ctr - 2'd1;
    return nxt;
  endfunction

endpackage

// File: rtl/bht_2bit.sv
// Branch history table of 2-bit saturating counters, untagged.
// One combinational read port, one registered read-modify-write update port.
// A same-cycle read of an entry being updated sees the pre-update value.
module bht_2bit
  import rv_pkg::*;
#(
  parameter int ENTRIES = 16,
  parameter int IDX_W   = $clog2(ENTRIES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [1:0]       rd_ctr,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic             wr_taken
);

  logic [1:0] ctr_q [ENTRIES];

  assign rd_ctr = ctr_q[rd_idx];

  // Counter array: reset to weakly not-taken, saturating update on resolve.
  // NOTE: this array is reset explicitly because predictions are architecturally
  // defined right after reset; a plain storage RAM would normally not be.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= CTR_WNT;
    end else if (wr_en) begin
      // NOTE: non-blocking so the read port sees the old value for the whole cycle.
      ctr_q[wr_idx] <= ctr_update(ctr_q[wr_idx], wr_taken);
    end
  end

endmodule

// File: rtl/branch_resolve_ctrl.sv
// Dynamic branch prediction and misprediction recovery for the 5-stage pipe.
// Decode gets a direction guess from the BHT; execute resolves branches, trains
// the BHT and, on a miss, redirects fetch and holds the front-end flushes.
module branch_resolve_ctrl
  import rv_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int BHT_ENTRIES  = 16,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            id_valid,
  input  logic [6:0]      id_op,
  input  logic [XLEN-1:0] id_pc,
  output logic            pred_taken,
  input  logic            ex_valid,
  input  logic            ex_is_branch,
  input  logic [XLEN-1:0] ex_pc,
  input  logic            ex_taken,
  input  logic            ex_pred_taken,
  input  logic [XLEN-1:0] ex_target,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic            flush_if_id,
  output logic            flush_id_ex,
  output logic [15:0]     branch_cnt,
  output logic [15:0]     mispred_cnt
);

  localparam int IDX_W = $clog2(BHT_ENTRIES);

  ctrl_state_e state_q;
  logic [2:0]  flush_ctr_q;
  logic        flush_q;
  logic [1:0]  rd_ctr;
  logic        resolve;
  logic        mispredict;
  logic        unused_id_pc;

  // Only word-index bits of the decode PC address the table.
  assign unused_id_pc = ^{id_pc[XLEN-1:IDX_W+2], id_pc[1:0]};

  assign resolve    = ex_valid && ex_is_branch && (state_q == IDLE);
  assign mispredict = resolve && (ex_taken != ex_pred_taken);

  assign flush_if_id = flush_q;
  assign flush_id_ex = flush_q;

  bht_2bit #(
    .ENTRIES (BHT_ENTRIES),
    .IDX_W   (IDX_W)
  ) u_bht (
    .clk      (clk),
    .rst      (rst),
    .rd_idx   (id_pc[IDX_W+1:2]),
    .rd_ctr   (rd_ctr),
    .wr_en    (resolve),
    .wr_idx   (ex_pc[IDX_W+1:2]),
    .wr_taken (ex_taken)
  );

  // Decode-stage prediction: JAL always taken, B-type follows the counter MSB.
  always_comb begin
    // NOTE: default first so every path assigns pred_taken and no latch is inferred.
    pred_taken = 1'b0;
    if (id_valid) begin
      if (id_op == OP_JAL) pred_taken = 1'b1;
      else if (id_op == OP_BRANCH) pred_taken = rd_ctr[1];
    end
  end

  // Recovery FSM with registered redirect, flush and statistics outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= IDLE;
      flush_ctr_q    <= 3'd0;
      flush_q        <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      branch_cnt     <= 16'd0;
      mispred_cnt    <= 16'd0;
    end else begin
      redirect_valid <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (resolve && branch_cnt != 16'hFFFF) branch_cnt <= branch_cnt + 16'd1;
          if (mispredict) begin
            state_q        <= FLUSH;
            flush_ctr_q    <= 3'(FLUSH_CYCLES);
            flush_q        <= 1'b1;
            redirect_valid <= 1'b1;
            redirect_pc    <= ex_taken ? ex_target : ex_pc + XLEN'(4);
            if (mispred_cnt != 16'hFFFF) mispred_cnt <= mispred_cnt + 16'd1;
          end
        end
        FLUSH: begin
          // Wrong-path execute results are ignored while the flush is held.
          if (flush_ctr_q == 3'd1) begin
            state_q     <= IDLE;
            flush_ctr_q <= 3'd0;
            flush_q     <= 1'b0;
          end else begin
            flush_ctr_q <= flush_ctr_q - 3'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Directed bench for branch_resolve_ctrl with a redirect scoreboard and a
// small reference model of the BHT and the statistics counters.
module tb_branch_resolve_ctrl;

  localparam int XLEN = 32;
  localparam int FC   = 2;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_ALU    = 7'b0110011;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            id_valid = 1'b0;
  logic [6:0]      id_op = '0;
  logic [XLEN-1:0] id_pc = '0;
  logic            pred_taken;
  logic            ex_valid = 1'b0;
  logic            ex_is_branch = 1'b0;
  logic [XLEN-1:0] ex_pc = '0;
  logic            ex_taken = 1'b0;
  logic            ex_pred_taken = 1'b0;
  logic [XLEN-1:0] ex_target = '0;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            flush_if_id;
  logic            flush_id_ex;
  logic [15:0]     branch_cnt;
  logic [15:0]     mispred_cnt;

  int n_cmp = 0;
  int n_mis = 0;

  logic [31:0] exp_q[$];
  logic [1:0]  bht_m [16];
  logic [15:0] bcnt_m;
  logic [15:0] mcnt_m;

  branch_resolve_ctrl #(
    .XLEN         (XLEN),
    .BHT_ENTRIES  (16),
    .FLUSH_CYCLES (FC)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .id_valid       (id_valid),
    .id_op          (id_op),
    .id_pc          (id_pc),
    .pred_taken     (pred_taken),
    .ex_valid       (ex_valid),
    .ex_is_branch   (ex_is_branch),
    .ex_pc          (ex_pc),
    .ex_taken       (ex_taken),
    .ex_pred_taken  (ex_pred_taken),
    .ex_target      (ex_target),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .flush_if_id    (flush_if_id),
    .flush_id_ex    (flush_id_ex),
    .branch_cnt     (branch_cnt),
    .mispred_cnt    (mispred_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_mis++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) bht_m[i] = 2'b01;
    bcnt_m = 16'd0;
    mcnt_m = 16'd0;
  endtask

  // Advance one cycle and sample just after the edge; any redirect is
  // matched against the oldest expected entry in the scoreboard.
  task automatic tick();
    @(posedge clk);
    #1;
    if (redirect_valid) begin
      if (exp_q.size() == 0) check("spurious_redirect", 32'(redirect_valid), 32'd0);
      else check("redirect_pc", redirect_pc, exp_q.pop_front());
    end
  endtask

  // Present one branch in execute for a single cycle while the controller is idle.
  task automatic resolve(input logic [31:0] pc, input logic taken, input logic pred,
                         input logic [31:0] target);
    logic [3:0] idx;
    idx = pc[5:2];
    ex_valid = 1'b1; ex_is_branch = 1'b1; ex_pc = pc;
    ex_taken = taken; ex_pred_taken = pred; ex_target = target;
    if (taken != pred) begin
      exp_q.push_back(taken ? target : pc + 32'd4);
      if (mcnt_m != 16'hFFFF) mcnt_m = mcnt_m + 16'd1;
    end
    if (bcnt_m != 16'hFFFF) bcnt_m = bcnt_m + 16'd1;
    if (taken && bht_m[idx] != 2'b11) bht_m[idx] = bht_m[idx] + 2'd1;
    else if (!taken && bht_m[idx] != 2'b00) bht_m[idx] = bht_m[idx] - 2'd1;
    tick();
    ex_valid = 1'b0; ex_is_branch = 1'b0;
  endtask

  task automatic pred_chk(input string tag, input logic [31:0] pc);
    id_valid = 1'b1; id_op = OP_BRANCH; id_pc = pc;
    #1;
    check(tag, 32'(pred_taken), 32'(bht_m[pc[5:2]][1]));
  endtask

  task automatic cnt_chk();
    check("branch_cnt", 32'(branch_cnt), 32'(bcnt_m));
    check("mispred_cnt", 32'(mispred_cnt), 32'(mcnt_m));
  endtask

  // Called in the cycle right after a mispredict was registered.
  task automatic flush_seq();
    check("redirect_valid_hi", 32'(redirect_valid), 32'd1);
    check("flush_if_id_hi", 32'(flush_if_id), 32'd1);
    check("flush_id_ex_hi", 32'(flush_id_ex), 32'd1);
    for (int i = 2; i <= FC; i++) begin
      tick();
      check("redirect_one_shot", 32'(redirect_valid), 32'd0);
      check("flush_hold", 32'({flush_if_id, flush_id_ex}), 32'd3);
    end
    tick();
    check("flush_drop", 32'({flush_if_id, flush_id_ex}), 32'd0);
  endtask

  initial begin
    model_reset();
    #12;
    check("rst_outputs", 32'({redirect_valid, flush_if_id, flush_id_ex}), 32'd0);
    rst = 1'b1;
    tick();

    // Reset state and decode prediction by opcode.
    pred_chk("pred_branch_reset", 32'h40);
    check("redirect_pc_reset", redirect_pc, 32'd0);
    check("flush_reset", 32'({flush_if_id, flush_id_ex, redirect_valid}), 32'd0);
    cnt_chk();
    id_op = OP_JAL; id_pc = 32'h1234; #1;
    check("pred_jal", 32'(pred_taken), 32'd1);
    id_op = OP_ALU; #1;
    check("pred_alu", 32'(pred_taken), 32'd0);
    id_op = OP_JAL; id_valid = 1'b0; #1;
    check("pred_invalid", 32'(pred_taken), 32'd0);

    // Taken mispredict with a wrong-path branch held in execute during FLUSH.
    resolve(32'h200, 1'b1, 1'b0, 32'h180);
    ex_valid = 1'b1; ex_is_branch = 1'b1; ex_pc = 32'h240;
    ex_taken = 1'b0; ex_pred_taken = 1'b1; ex_target = 32'h500;
    cnt_chk();
    pred_chk("pred_after_train", 32'h200);
    flush_seq();
    ex_valid = 1'b0; ex_is_branch = 1'b0;
    check("redirect_pc_hold", redirect_pc, 32'h180);
    cnt_chk();
    pred_chk("pred_flush_ignored", 32'h200);

    // Not-taken mispredict: fall-through address.
    resolve(32'h300, 1'b0, 1'b1, 32'h999);
    flush_seq();
    cnt_chk();

    // Correct predictions: train up without any redirect or flush.
    resolve(32'h200, 1'b1, 1'b1, 32'h180);
    resolve(32'h200, 1'b1, 1'b1, 32'h180);
    check("correct_no_redirect", 32'({redirect_valid, flush_if_id}), 32'd0);
    cnt_chk();
    pred_chk("pred_correct_train", 32'h200);

    // Aliasing between 0x100 and 0x140, then read-during-write returns old value.
    for (int i = 0; i < 3; i++) resolve(32'h100, 1'b1, 1'b1, 32'h0);
    pred_chk("pred_alias", 32'h140);
    resolve(32'h100, 1'b0, 1'b0, 32'h0);
    id_pc = 32'h140;
    ex_valid = 1'b1; ex_is_branch = 1'b1; ex_pc = 32'h100;
    ex_taken = 1'b0; ex_pred_taken = 1'b0;
    #1;
    check("pred_read_old", 32'(pred_taken), 32'd1);
    ex_valid = 1'b0;
    resolve(32'h100, 1'b0, 1'b0, 32'h0);
    pred_chk("pred_after_write", 32'h140);

    // Saturation at SNT, then climb back out.
    for (int i = 0; i < 4; i++) resolve(32'h100, 1'b0, 1'b0, 32'h0);
    pred_chk("pred_snt", 32'h140);
    resolve(32'h100, 1'b1, 1'b0, 32'h0);
    flush_seq();
    pred_chk("pred_wnt_from_snt", 32'h140);
    resolve(32'h100, 1'b1, 1'b1, 32'h0);
    pred_chk("pred_wt_from_wnt", 32'h140);

    // Fall-through PC wraps at the top of the address space.
    resolve(32'hFFFF_FFFC, 1'b0, 1'b1, 32'h0);
    flush_seq();
    cnt_chk();

    // Run branch_cnt into saturation and one past it.
    begin
      int n;
      n = 65535 - int'(bcnt_m) + 1;
      ex_valid = 1'b1; ex_is_branch = 1'b1; ex_pc = 32'h4;
      ex_taken = 1'b0; ex_pred_taken = 1'b0;
      for (int i = 0; i < n; i++) tick();
      ex_valid = 1'b0; ex_is_branch = 1'b0;
      bcnt_m = 16'hFFFF;
      bht_m[1] = 2'b00;
      cnt_chk();
    end

    // Reset in the middle of a flush.
    resolve(32'h8, 1'b1, 1'b0, 32'h40);
    check("flush_before_rst", 32'(flush_if_id), 32'd1);
    #1;
    rst = 1'b0;
    #1;
    model_reset();
    check("rst_mid_flush", 32'({flush_if_id, flush_id_ex, redirect_valid}), 32'd0);
    cnt_chk();
    #1;
    rst = 1'b1;
    pred_chk("pred_bht_reset", 32'h200);
    resolve(32'h10, 1'b0, 1'b1, 32'h0);
    flush_seq();
    cnt_chk();

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
